// File: rtl/bft_pkg.sv
// Shared definitions for the BFT leaf endpoint.
// Holds the packet field positions, the packet type codes, the packet and
// payload widths, and a helper that assembles an outgoing packet.
package bft_pkg;

  localparam int PACKET_BITS  = 49;
  localparam int PAYLOAD_BITS = 32;

  localparam int VALID_BIT    = 48;
  localparam int LEAF_MSB     = 47;
  localparam int LEAF_LSB     = 45;
  localparam int PORT_MSB     = 44;
  localparam int PORT_LSB     = 41;
  localparam int TYPE_MSB     = 40;
  localparam int TYPE_LSB     = 39;
  localparam int SEQ_MSB      = 38;
  localparam int SEQ_LSB      = 32;
  localparam int PAYLOAD_MSB  = 31;
  localparam int PAYLOAD_LSB  = 0;

  localparam int LEAF_W = LEAF_MSB - LEAF_LSB + 1;
  localparam int PORT_W = PORT_MSB - PORT_LSB + 1;
  localparam int SEQ_W  = SEQ_MSB - SEQ_LSB + 1;

  typedef enum logic [1:0] {
    TYPE_DATA      = 2'b00,
    TYPE_FREESPACE = 2'b01,
    TYPE_RSVD0     = 2'b10,
    TYPE_RSVD1     = 2'b11
  } pkt_type_e;

  function automatic logic [PACKET_BITS-1:0] make_pkt(
    input logic [LEAF_W-1:0]       leaf,
    input logic [PORT_W-1:0]       port,
    input pkt_type_e               ptype,
    input logic [SEQ_W-1:0]        seq,
    input logic [PAYLOAD_BITS-1:0] payload
  );
    return {1'b1, leaf, port, ptype, seq, payload};
  endfunction

endpackage

// File: rtl/bft_rx_fifo.sv
// Synchronous receive FIFO for the BFT leaf endpoint.
// Ports: clk_i/rst_n_i clock and async active-low reset; push_i/wdata_i write
// side (ignored when full); pop_i read side (ignored when empty); rdata_o is
// the head word (zero when empty); full_o/empty_o status flags.
module bft_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/bft_leaf_endpoint.sv
// BFT leaf endpoint: credit-based packet transmitter plus filtered receiver.
// Ports: clk_bft/reset_n clock and async active-low reset;
//   din_leaf2bft  packet from leaf,  dout_bft2leaf registered packet to leaf;
//   tx_data/tx_vld/tx_ack user send handshake (tx_ack combinational);
//   rx_data/rx_vld/rx_ack user receive handshake;
//   credits current TX credits; rx_drop one-cycle pulse per dropped packet.
module bft_leaf_endpoint #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 3,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int SELF_LEAF     = 0,
  parameter int DEST_LEAF     = 1,
  parameter int DEST_PORT     = 1,
  parameter int RX_SRC_PORT   = 1,
  parameter int INIT_CREDITS  = 16,
  parameter int CREDIT_BITS   = 8,
  parameter int RX_FIFO_DEPTH = 16,
  parameter int UPDATE_SIZE   = 4
) (
  input  logic                    clk_bft,
  input  logic                    reset_n,
  input  logic [PACKET_BITS-1:0]  din_leaf2bft,
  output logic [PACKET_BITS-1:0]  dout_bft2leaf,
  input  logic [PAYLOAD_BITS-1:0] tx_data,
  input  logic                    tx_vld,
  output logic                    tx_ack,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_vld,
  input  logic                    rx_ack,
  output logic [CREDIT_BITS-1:0]  credits,
  output logic                    rx_drop
);
  import bft_pkg::*;

  // Counter is wide enough for a full update plus one pop folded in while pending.
  localparam int CNT_W = $clog2(UPDATE_SIZE + 2);
  localparam logic [NUM_LEAF_BITS-1:0] SELF_L   = NUM_LEAF_BITS'(SELF_LEAF);
  localparam logic [NUM_PORT_BITS-1:0] RX_PORT_L = NUM_PORT_BITS'(RX_SRC_PORT);
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(UPDATE_SIZE - 1);
  localparam logic [CNT_W-1:0]         CNT_UPD  = CNT_W'(UPDATE_SIZE);
  localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_ADDR_BITS-1:0] SEQ_ONE  = NUM_ADDR_BITS'(1);

  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [NUM_ADDR_BITS-1:0] seq_q, seq_d;
  logic [CREDIT_BITS-1:0]   credits_q, credits_d;
  logic                     drop_q, drop_d;
  logic                     pend_q, pend_d;
  logic [CNT_W-1:0]         cons_q, cons_d;

  logic                     rx_valid;
  logic [NUM_LEAF_BITS-1:0] rx_leaf;
  logic [NUM_PORT_BITS-1:0] rx_port;
  logic [1:0]               rx_type;
  logic [PAYLOAD_BITS-1:0]  rx_payload;
  logic [SEQ_W-1:0]         unused_rx_seq;

  logic fs_hit, data_hit, push, pop, tx_hs;
  logic fifo_full, fifo_empty;
  logic [CNT_W-1:0]         fs_count;
  logic [PAYLOAD_BITS-1:0]  fs_payload;
  logic [CREDIT_BITS:0]     credit_sum;

  assign rx_valid      = din_leaf2bft[VALID_BIT];
  assign rx_leaf       = din_leaf2bft[LEAF_MSB:LEAF_LSB];
  assign rx_port       = din_leaf2bft[PORT_MSB:PORT_LSB];
  assign rx_type       = din_leaf2bft[TYPE_MSB:TYPE_LSB];
  assign rx_payload    = din_leaf2bft[PAYLOAD_MSB:PAYLOAD_LSB];
  assign unused_rx_seq = din_leaf2bft[SEQ_MSB:SEQ_LSB];

  // Freespace packets only need the right leaf; data also needs the right port.
  assign fs_hit   = rx_valid && (rx_leaf == SELF_L) && (rx_type == TYPE_FREESPACE);
  assign data_hit = rx_valid && (rx_leaf == SELF_L) && (rx_type == TYPE_DATA) &&
                    (rx_port == RX_PORT_L);
  // Full is judged before any same-cycle pop, so push-while-full is a drop.
  assign push     = data_hit && !fifo_full;
  assign drop_d   = rx_valid && !fs_hit && !push;

  assign pop      = rx_vld && rx_ack;
  // Pending freespace update owns the output slot, so user data is held off.
  assign tx_ack   = reset_n && tx_vld && (credits_q != '0) && !pend_q;
  assign tx_hs    = tx_ack;

  assign fs_count   = CNT_UPD + {{(CNT_W-1){1'b0}}, pop};
  assign fs_payload = {{(PAYLOAD_BITS-CNT_W){1'b0}}, fs_count};

  always_comb begin
    dout_d = '0;
    if (pend_q) begin
      dout_d = make_pkt(LEAF_W'(DEST_LEAF), PORT_W'(RX_SRC_PORT), TYPE_FREESPACE,
                        '0, fs_payload);
    end else if (tx_hs) begin
      dout_d = make_pkt(LEAF_W'(DEST_LEAF), PORT_W'(DEST_PORT), TYPE_DATA,
                        SEQ_W'(seq_q), tx_data);
    end
  end

  assign seq_d = tx_hs ? seq_q + SEQ_ONE : seq_q;

  // Add and subtract in one step, one bit wider, then saturate high.
  assign credit_sum = {1'b0, credits_q}
                    + (fs_hit ? {1'b0, rx_payload[CREDIT_BITS-1:0]} : '0)
                    - {{CREDIT_BITS{1'b0}}, tx_hs};
  assign credits_d  = credit_sum[CREDIT_BITS] ? '1 : credit_sum[CREDIT_BITS-1:0];

  // A pop landing while an update is pending rides along in that update.
  always_comb begin
    cons_d = cons_q;
    pend_d = pend_q;
    if (pend_q) begin
      pend_d = 1'b0;
      cons_d = '0;
    end else if (pop) begin
      if (cons_q == CNT_LAST) begin
        cons_d = '0;
        pend_d = 1'b1;
      end else begin
        cons_d = cons_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_bft or negedge reset_n) begin
    if (!reset_n) begin
      dout_q    <= '0;
      seq_q     <= '0;
      credits_q <= CREDIT_BITS'(INIT_CREDITS);
      drop_q    <= 1'b0;
      pend_q    <= 1'b0;
      cons_q    <= '0;
    end else begin
      dout_q    <= dout_d;
      seq_q     <= seq_d;
      credits_q <= credits_d;
      drop_q    <= drop_d;
      pend_q    <= pend_d;
      cons_q    <= cons_d;
    end
  end

  bft_rx_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_bft),
    .rst_n_i (reset_n),
    .push_i  (push),
    .wdata_i (rx_payload),
    .pop_i   (rx_ack),
    .rdata_o (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_vld        = !fifo_empty;
  assign dout_bft2leaf = dout_q;
  assign credits       = credits_q;
  assign rx_drop       = drop_q;

endmodule
